// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment bus observer: active-low glyphs
// (bit 0 = segment a ... bit 6 = segment g), the blank pattern and FSM states.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bin4.sv
// Inverse glyph lookup: active-low cathode pattern to hex nibble.
module seg7_to_bin4
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_legal
);

  // Table lookup; anything outside the 16 glyphs and blank is illegal.
  always_comb begin
    nibble   = 4'h0;
    is_legal = 1'b1;
    is_blank = (seg == SEG_BLANK);
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Observes the multiplexed active-low seven-segment bus and recovers the
// four displayed hex digits, filtering anode-switch ghosting with a
// stability window and flagging illegal cathode patterns.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        code_error,
  output logic [1:0]  err_digit
);

  localparam int             CW      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [6:0]    r_seg_s1, r_seg_s2;
  logic [3:0]    r_an_s1, r_an_s2;
  logic [10:0]   r_prev;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_seen;
  scan_state_t   r_state;

  logic [10:0]   w_cur;
  logic          w_changed;
  logic          w_onehot;
  logic [1:0]    w_idx;
  logic [3:0]    w_seen_set;
  logic [3:0]    w_nibble;
  logic          w_is_blank;
  logic          w_is_legal;

  // Two-flop synchronizer; idles at all-ones (no anode, all segments off).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_in;
      r_an_s2  <= r_an_s1;
    end
  end

  assign w_cur      = {r_an_s2, r_seg_s2};
  assign w_changed  = (w_cur != r_prev);
  assign w_seen_set = r_seen | (4'b0001 << w_idx);

  // Active digit: exactly one low anode bit, anything else means no digit.
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_an_s2)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  seg7_to_bin4 u_dec (
    .seg      (r_seg_s2),
    .nibble   (w_nibble),
    .is_blank (w_is_blank),
    .is_legal (w_is_legal)
  );

  // Dwell FSM: restart the window on any bus change, sample once per dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_prev      <= '1;
      r_seen      <= '0;
      value       <= '0;
      digit_valid <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      code_error  <= 1'b0;
      err_digit   <= '0;
    end else begin
      r_prev      <= w_cur;
      frame_valid <= 1'b0;
      code_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_onehot) begin
            r_state <= SETTLING;
            r_cnt   <= CNT_ONE;
          end
        end
        SETTLING: begin
          if (!w_onehot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_changed) begin
            r_cnt <= CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= HELD;
            if (w_is_legal) begin
              value[{w_idx, 2'b00} +: 4] <= w_nibble;
              digit_valid[w_idx]         <= 1'b1;
              blank[w_idx]               <= 1'b0;
            end else if (w_is_blank) begin
              blank[w_idx]       <= 1'b1;
              digit_valid[w_idx] <= 1'b0;
            end else begin
              code_error         <= 1'b1;
              err_digit          <= w_idx;
              digit_valid[w_idx] <= 1'b0;
            end
            if (w_seen_set == 4'hF) begin
              frame_valid <= 1'b1;
              r_seen      <= '0;
            end else begin
              r_seen <= w_seen_set;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!w_onehot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_changed) begin
            r_state <= SETTLING;
            r_cnt   <= CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder at the default settle window.
module tb_sevenseg_scan_decoder;

  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12;
  localparam logic [6:0] G6 = 7'h02;
  localparam logic [6:0] G8 = 7'h00;
  localparam logic [6:0] G9 = 7'h10;
  localparam logic [6:0] GBLANK = 7'h7F;
  localparam logic [6:0] GBAD = 7'h55;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        code_error;
  logic [1:0]  err_digit;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value       (value),
    .digit_valid (digit_valid),
    .blank       (blank),
    .frame_valid (frame_valid),
    .code_error  (code_error),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one dwell for n cycles, counting pulses and value/status changes.
  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n,
                       output int n_frame, output int n_err, output int n_chg);
    logic [23:0] prev;
    an_in  = an;
    seg_in = seg;
    n_frame = 0;
    n_err   = 0;
    n_chg   = 0;
    prev = {value, digit_valid, blank};
    for (int i = 0; i < n; i++) begin
      step();
      if (frame_valid) n_frame++;
      if (code_error) n_err++;
      if ({value, digit_valid, blank} !== prev) n_chg++;
      prev = {value, digit_valid, blank};
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    an_in  = 4'hF;
    seg_in = GBLANK;
    repeat (3) step();
    checks++;
    if ({value, digit_valid, blank, frame_valid, code_error, err_digit} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0",
               {value, digit_valid, blank, frame_valid, code_error, err_digit});
    end
    reset = 1'b0;
  endtask

  task automatic test_legal_scan();
    int f, e, c, ft, et;
    an_in  = 4'b0111;
    seg_in = G1;
    repeat (6) step();
    checks++;
    if (digit_valid !== 4'h0 || value !== 16'h0000) begin
      errors++;
      $display("FAIL latency_early: dv=%h value=%h, want dv=0 value=0000", digit_valid, value);
    end
    step();
    checks++;
    if (digit_valid !== 4'b1000 || value !== 16'h1000) begin
      errors++;
      $display("FAIL latency_edge: dv=%h value=%h, want dv=8 value=1000", digit_valid, value);
    end
    dwell(4'b0111, G1, 13, f, e, c); ft = f; et = e;
    dwell(4'b1011, G2, 20, f, e, c); ft += f; et += e;
    dwell(4'b1101, G3, 20, f, e, c); ft += f; et += e;
    dwell(4'b1110, G4, 20, f, e, c); ft += f; et += e;
    checks++;
    if (value !== 16'h1234 || digit_valid !== 4'hF) begin
      errors++;
      $display("FAIL scan1_value: value=%h dv=%h, want 1234 F", value, digit_valid);
    end
    checks++;
    if (ft !== 1 || et !== 0) begin
      errors++;
      $display("FAIL scan1_pulses: frames=%0d errs=%0d, want 1 0", ft, et);
    end
    dwell(4'b0111, G1, 20, f, e, c); ft = f;
    dwell(4'b1011, G2, 20, f, e, c); ft += f;
    dwell(4'b1101, G3, 20, f, e, c); ft += f;
    dwell(4'b1110, G4, 20, f, e, c); ft += f;
    checks++;
    if (ft !== 1 || value !== 16'h1234) begin
      errors++;
      $display("FAIL scan2: frames=%0d value=%h, want 1 1234", ft, value);
    end
  endtask

  task automatic test_ghost_filter();
    int f, e, c1, c2;
    dwell(4'b1110, G5, 3, f, e, c1);
    checks++;
    if (c1 !== 0 || value !== 16'h1234) begin
      errors++;
      $display("FAIL ghost_short: changes=%0d value=%h, want 0 1234", c1, value);
    end
    dwell(4'b1110, G6, 20, f, e, c2);
    checks++;
    if (c2 !== 1 || value !== 16'h1236) begin
      errors++;
      $display("FAIL ghost_steady: changes=%0d value=%h, want 1 1236", c2, value);
    end
  endtask

  task automatic test_illegal();
    int f, e, c, ft, et;
    dwell(4'b0111, G1, 20, f, e, c); ft = f; et = e;
    dwell(4'b1011, GBAD, 20, f, e, c); ft += f; et += e;
    checks++;
    if (et !== 1 || err_digit !== 2'd2) begin
      errors++;
      $display("FAIL illegal_err: pulses=%0d err_digit=%0d, want 1 2", et, err_digit);
    end
    checks++;
    if (digit_valid !== 4'b1011 || value !== 16'h1236) begin
      errors++;
      $display("FAIL illegal_state: dv=%h value=%h, want B 1236", digit_valid, value);
    end
    dwell(4'b1101, G3, 20, f, e, c); ft += f; et += e;
    checks++;
    if (ft !== 1 || et !== 1) begin
      errors++;
      $display("FAIL illegal_frame: frames=%0d errs=%0d, want 1 1", ft, et);
    end
  endtask

  task automatic test_blank_bad_anodes();
    int f, e, c;
    logic [23:0] snap;
    dwell(4'b1101, GBLANK, 20, f, e, c);
    checks++;
    if (blank !== 4'b0010 || digit_valid !== 4'b1001 || value !== 16'h1236 || e !== 0) begin
      errors++;
      $display("FAIL blank_digit: blank=%h dv=%h value=%h errs=%0d, want 2 9 1236 0",
               blank, digit_valid, value, e);
    end
    snap = {value, digit_valid, blank};
    dwell(4'b0011, G8, 50, f, e, c);
    checks++;
    if ({value, digit_valid, blank} !== snap || f !== 0 || e !== 0 || c !== 0) begin
      errors++;
      $display("FAIL bad_anodes: state=%h frames=%0d errs=%0d chg=%0d, want %h 0 0 0",
               {value, digit_valid, blank}, f, e, c, snap);
    end
    dwell(4'b1101, G3, 20, f, e, c);
    checks++;
    if (blank !== 4'b0000 || digit_valid !== 4'b1011) begin
      errors++;
      $display("FAIL unblank: blank=%h dv=%h, want 0 B", blank, digit_valid);
    end
  endtask

  task automatic test_reset_mid_dwell();
    an_in  = 4'b1110;
    seg_in = G9;
    repeat (4) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({value, digit_valid, blank, frame_valid, code_error, err_digit} !== 30'd0) begin
      errors++;
      $display("FAIL reset_async: got %h, want 0",
               {value, digit_valid, blank, frame_valid, code_error, err_digit});
    end
    step();
    reset = 1'b0;
    repeat (6) step();
    checks++;
    if (value !== 16'h0000 || digit_valid !== 4'h0) begin
      errors++;
      $display("FAIL reset_window_early: value=%h dv=%h, want 0000 0", value, digit_valid);
    end
    step();
    checks++;
    if (value !== 16'h0009 || digit_valid !== 4'b0001) begin
      errors++;
      $display("FAIL reset_window_edge: value=%h dv=%h, want 0009 1", value, digit_valid);
    end
  endtask

  initial begin
    test_reset();
    test_legal_scan();
    test_ghost_filter();
    test_illegal();
    test_blank_bad_anodes();
    test_reset_mid_dwell();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
